seg7_scan_ctrl: RTL

//  Time-multiplexed scanner for the 4-digit 7-segment display: rotates digit enables at a fixed slot rate,

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_decoder.sv | 16 +
 rtl/seg7_scan_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit 7-segment scan controller.
//  - scan_state_e : scanner FSM states
//  - NUM_DIG/SEG_W: digit count and segment-pattern width
//  - SEG_TABLE    : hex nibble -> {g,f,e,d,c,b,a} pattern, active high
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  localparam int NUM_DIG = 4;
  localparam int SEG_W   = 7;

  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-7-segment decoder.
//  nib_i : 4-bit hex nibble
//  seg_o : segment pattern {g,f,e,d,c,b,a}, active high
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0]       nib_i,
  output logic [SEG_W-1:0] seg_o
);

  // table lookup of the segment pattern
  always_comb begin
    seg_o = SEG_TABLE[nib_i];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scanner for a 4-digit 7-segment display.
// Each digit slot is SCAN_DIV cycles: BLANK_CYC dark cycles, then the digit
// is shown. New display values arrive over a valid/ready handshake into a
// one-entry pending buffer and are applied only at frame boundaries (or at
// any time while idle), so a frame is never torn.
//  clk, rst_n          : clock, async active-low reset
//  en                  : 1 = scan, 0 = dark/idle
//  data_in, dp_in      : four hex nibbles and decimal points (bit i -> digit i+1)
//  dig_mask            : per-digit lit enable (slot timing unaffected)
//  data_vld, data_rdy  : producer handshake
//  d7seg, dp, dig1..4  : registered display pins, active high
//  frame_done          : 1-cycle pulse at the end of the digit-4 slot
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [15:0]      data_in,
  input  logic [3:0]       dp_in,
  input  logic [3:0]       dig_mask,
  input  logic             data_vld,
  output logic             data_rdy,
  output logic [SEG_W-1:0] d7seg,
  output logic             dp,
  output logic             dig1,
  output logic             dig2,
  output logic             dig3,
  output logic             dig4,
  output logic             frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // {data nibbles[15:0], decimal points[3:0]}
  scan_state_e      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [19:0]      pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [19:0]      act_q, act_d;
  logic             rdy_q, rdy_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       dig_q, dig_d;
  logic             fd_q, fd_d;

  logic             frame_end_s;
  logic             xfer_s;
  logic             apply_s;
  logic [15:0]      act_data_s;
  logic [3:0]       cur_nib_s;
  logic [SEG_W-1:0] dec_seg_s;

  assign act_data_s  = act_q[19:4];
  assign cur_nib_s   = act_data_s[{idx_q, 2'b00} +: 4];
  assign frame_end_s = (state_q == SHOW) && (idx_q == 2'd3) && (cnt_q == CNT_LAST);

  seg7_decoder u_dec (
    .nib_i (cur_nib_s),
    .seg_o (dec_seg_s)
  );

  // scan FSM: slot counter and digit index; en low forces IDLE from any state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
          end else begin
            state_d = BLANK;
          end
        end
        SHOW: begin
          if (cnt_q == CNT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // handshake and pending/active buffers; ready mirrors an empty pending slot
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    act_d       = act_q;
    xfer_s      = data_vld && rdy_q;
    // a transfer needs an empty pending slot, so it never coincides with an apply
    apply_s     = pend_full_q && ((state_q == IDLE) || frame_end_s);
    if (apply_s) begin
      act_d       = pend_q;
      pend_full_d = 1'b0;
    end else if (xfer_s) begin
      pend_d      = {data_in, dp_in};
      pend_full_d = 1'b1;
    end else begin
      pend_full_d = pend_full_q;
    end
    rdy_d = !pend_full_d;
  end

  // next pin values; gated by en so dropping it darkens the display on the next cycle
  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    dig_d = 4'b0000;
    fd_d  = 1'b0;
    if (en && (state_q == SHOW)) begin
      if (dig_mask[idx_q]) begin
        dig_d[idx_q] = 1'b1;
        seg_d        = dec_seg_s;
        dp_d         = act_q[idx_q];
      end else begin
        dig_d = 4'b0000;
      end
      fd_d = frame_end_s;
    end else begin
      fd_d = 1'b0;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      pend_q      <= 20'd0;
      pend_full_q <= 1'b0;
      act_q       <= 20'd0;
      rdy_q       <= 1'b0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      dig_q       <= 4'b0000;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      act_q       <= act_d;
      rdy_q       <= rdy_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      dig_q       <= dig_d;
      fd_q        <= fd_d;
    end
  end

  assign data_rdy   = rdy_q;
  assign d7seg      = seg_q;
  assign dp         = dp_q;
  assign dig1       = dig_q[0];
  assign dig2       = dig_q[1];
  assign dig3       = dig_q[2];
  assign dig4       = dig_q[3];
  assign frame_done = fd_q;

endmodule
